// File: rtl/peripheral_spram_ahb3_bridge_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : peripheral_spram_ahb3_bridge_pkg                            |
// | Brief  : AHB3 transfer/size/response codes and bridge state type     |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
package peripheral_spram_ahb3_bridge_pkg;

  localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] c_HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] c_HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] c_HSIZE_BYTE   = 3'b000;
  localparam logic [2:0] c_HSIZE_HWORD  = 3'b001;
  localparam logic [2:0] c_HSIZE_WORD   = 3'b010;
  localparam logic [2:0] c_HSIZE_DWORD  = 3'b011;
  localparam logic [2:0] c_HSIZE_128    = 3'b100;
  localparam logic [2:0] c_HSIZE_256    = 3'b101;
  localparam logic [2:0] c_HSIZE_512    = 3'b110;
  localparam logic [2:0] c_HSIZE_1024   = 3'b111;

  localparam logic c_HRESP_OKAY  = 1'b0;
  localparam logic c_HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_OKAY = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } resp_state_e;

  function automatic logic htrans_active(input logic [1:0] htrans);
    return (htrans == c_HTRANS_NONSEQ) || (htrans == c_HTRANS_SEQ);
  endfunction

endpackage
`default_nettype wire

// File: rtl/peripheral_spram_ahb3_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : peripheral_spram_ahb3_bridge                                |
// | Brief  : zero-wait AHB3 slave front end for an external 1-port RAM   |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module peripheral_spram_ahb3_bridge
  import peripheral_spram_ahb3_bridge_pkg::*;
#(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32,
  parameter int MEM_ABITS  = 10
) (
  input  logic                    rst_ni,
  input  logic                    clk_i,
  input  logic                    HSEL,
  input  logic [HADDR_SIZE-1:0]   HADDR,
  input  logic [HDATA_SIZE-1:0]   HWDATA,
  output logic [HDATA_SIZE-1:0]   HRDATA,
  input  logic                    HWRITE,
  input  logic [2:0]              HSIZE,
  input  logic [2:0]              HBURST,
  input  logic [3:0]              HPROT,
  input  logic [1:0]              HTRANS,
  input  logic                    HMASTLOCK,
  input  logic                    HREADY,
  output logic                    HREADYOUT,
  output logic                    HRESP,
  output logic [MEM_ABITS-1:0]    mem_waddr_o,
  output logic [HDATA_SIZE-1:0]   mem_din_o,
  output logic                    mem_we_o,
  output logic [HDATA_SIZE/8-1:0] mem_be_o,
  output logic [MEM_ABITS-1:0]    mem_raddr_o,
  input  logic [HDATA_SIZE-1:0]   mem_dout_i
);

  localparam int c_BYTES = HDATA_SIZE / 8;
  localparam int c_BOFF  = $clog2(c_BYTES);

  resp_state_e            r_state;
  resp_state_e            w_state_nxt;

  logic                   w_accept;
  logic                   w_err;
  logic                   w_wr_req;
  logic                   w_rd_req;
  logic [MEM_ABITS-1:0]   w_waddr;
  logic [31:0]            w_off;
  logic [31:0]            w_size;
  logic [c_BYTES-1:0]     w_be;

  logic                   r_wr_pend;
  logic                   r_rd_pend;
  logic [MEM_ABITS-1:0]   r_waddr;
  logic [c_BYTES-1:0]     r_be;
  logic                   r_byp;
  logic [HDATA_SIZE-1:0]  r_byp_data;
  logic [c_BYTES-1:0]     r_byp_be;

  logic                   w_unused;

  // Upper address bits are dropped so the RAM image wraps through the map.
  assign w_waddr  = HADDR[MEM_ABITS+c_BOFF-1:c_BOFF];
  assign w_off    = 32'(HADDR[c_BOFF-1:0]);
  assign w_size   = 32'd1 << HSIZE;
  assign w_err    = (w_size > 32'(c_BYTES)) || ((w_off & (w_size - 32'd1)) != 32'd0);
  assign w_accept = HSEL & HREADY & htrans_active(HTRANS);
  assign w_wr_req = w_accept & HWRITE & ~w_err;
  assign w_rd_req = w_accept & ~HWRITE & ~w_err;
  assign w_unused = ^{HBURST, HPROT, HMASTLOCK, HADDR};

  always_comb begin
    w_be = '0;
    for (int i = 0; i < c_BYTES; i++) begin
      w_be[i] = (32'(i) >= w_off) && (32'(i) < (w_off + w_size));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_OKAY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    HREADYOUT   = 1'b1;
    HRESP       = c_HRESP_OKAY;
    unique case (r_state)
      ST_OKAY: begin
        if (w_accept && w_err) w_state_nxt = ST_ERR1;
      end
      ST_ERR1: begin
        HREADYOUT   = 1'b0;
        HRESP       = c_HRESP_ERROR;
        w_state_nxt = ST_ERR2;
      end
      ST_ERR2: begin
        HRESP       = c_HRESP_ERROR;
        w_state_nxt = ST_OKAY;
      end
      default: w_state_nxt = ST_OKAY;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_pend  <= 1'b0;
      r_rd_pend  <= 1'b0;
      r_waddr    <= '0;
      r_be       <= '0;
      r_byp      <= 1'b0;
      r_byp_data <= '0;
      r_byp_be   <= '0;
    end else begin
      r_wr_pend <= w_wr_req;
      r_rd_pend <= w_rd_req;
      if (w_wr_req) begin
        r_waddr <= w_waddr;
        r_be    <= w_be;
      end
      // RAM returns the pre-write word when a read hits the word being written.
      r_byp <= w_rd_req & r_wr_pend & (w_waddr == r_waddr);
      if (w_rd_req && r_wr_pend) begin
        r_byp_data <= HWDATA;
        r_byp_be   <= r_be;
      end
    end
  end

  assign mem_we_o    = r_wr_pend;
  assign mem_waddr_o = r_waddr;
  assign mem_din_o   = HWDATA;
  assign mem_be_o    = r_wr_pend ? r_be : '0;
  assign mem_raddr_o = w_waddr;

  always_comb begin
    HRDATA = '0;
    if (r_rd_pend) begin
      for (int i = 0; i < c_BYTES; i++) begin
        HRDATA[8*i +: 8] = (r_byp && r_byp_be[i]) ? r_byp_data[8*i +: 8] : mem_dout_i[8*i +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_peripheral_spram_ahb3_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_peripheral_spram_ahb3_bridge                             |
// | Brief  : directed self-checking bench with a registered-read RAM     |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_peripheral_spram_ahb3_bridge;

  localparam logic [1:0] c_IDLE   = 2'b00;
  localparam logic [1:0] c_NONSEQ = 2'b10;
  localparam logic [1:0] c_SEQ    = 2'b11;
  localparam logic [2:0] c_BYTE   = 3'd0;
  localparam logic [2:0] c_HALF   = 3'd1;
  localparam logic [2:0] c_WORD   = 3'd2;
  localparam logic [2:0] c_DWORD  = 3'd3;

  logic        rst_ni;
  logic        clk_i;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HMASTLOCK;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [9:0]  mem_waddr_o;
  logic [31:0] mem_din_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [9:0]  mem_raddr_o;
  logic [31:0] mem_dout_i;

  int n_total;
  int n_bad;

  logic [31:0] ram [0:1023];

  peripheral_spram_ahb3_bridge #(
    .HADDR_SIZE (32),
    .HDATA_SIZE (32),
    .MEM_ABITS  (10)
  ) dut (
    .rst_ni      (rst_ni),
    .clk_i       (clk_i),
    .HSEL        (HSEL),
    .HADDR       (HADDR),
    .HWDATA      (HWDATA),
    .HRDATA      (HRDATA),
    .HWRITE      (HWRITE),
    .HSIZE       (HSIZE),
    .HBURST      (HBURST),
    .HPROT       (HPROT),
    .HTRANS      (HTRANS),
    .HMASTLOCK   (HMASTLOCK),
    .HREADY      (HREADY),
    .HREADYOUT   (HREADYOUT),
    .HRESP       (HRESP),
    .mem_waddr_o (mem_waddr_o),
    .mem_din_o   (mem_din_o),
    .mem_we_o    (mem_we_o),
    .mem_be_o    (mem_be_o),
    .mem_raddr_o (mem_raddr_o),
    .mem_dout_i  (mem_dout_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Plain single-port RAM: registered read, old data returned on a same-cycle write.
  always @(posedge clk_i) begin
    if (mem_we_o) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_be_o[i]) ram[mem_waddr_o][8*i +: 8] <= mem_din_o[8*i +: 8];
      end
    end
    mem_dout_i <= ram[mem_raddr_o];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One bus cycle: new address phase plus write data for the previous one.
  task automatic setup(input logic [31:0] a, input logic w, input logic [2:0] sz,
                       input logic [1:0] tr, input logic [31:0] wd);
    @(negedge clk_i);
    HSEL   = 1'b1;
    HREADY = 1'b1;
    HADDR  = a;
    HWRITE = w;
    HSIZE  = sz;
    HTRANS = tr;
    HWDATA = wd;
    #1;
  endtask

  task automatic wr_word(input logic [31:0] a, input logic [31:0] d);
    setup(a, 1'b1, c_WORD, c_NONSEQ, 32'h0);
    setup(32'h0, 1'b0, c_WORD, c_IDLE, d);
  endtask

  initial begin
    n_total   = 0;
    n_bad     = 0;
    rst_ni    = 1'b0;
    HSEL      = 1'b0;
    HADDR     = '0;
    HWDATA    = '0;
    HWRITE    = 1'b0;
    HSIZE     = c_WORD;
    HBURST    = 3'd0;
    HPROT     = 4'd0;
    HTRANS    = c_IDLE;
    HMASTLOCK = 1'b0;
    HREADY    = 1'b1;

    repeat (2) @(negedge clk_i);
    #1;
    check("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    check("rst_hresp",     32'(HRESP),     32'd0);
    check("rst_hrdata",    HRDATA,         32'h0);
    check("rst_we",        32'(mem_we_o),  32'd0);
    check("rst_be",        32'(mem_be_o),  32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Word write then word read
    setup(32'h10, 1'b1, c_WORD, c_NONSEQ, 32'h0);
    setup(32'h0, 1'b0, c_WORD, c_IDLE, 32'hDEADBEEF);
    check("w1_we",    32'(mem_we_o),    32'd1);
    check("w1_be",    32'(mem_be_o),    32'hF);
    check("w1_waddr", 32'(mem_waddr_o), 32'd4);
    check("w1_din",   mem_din_o,        32'hDEADBEEF);
    check("w1_ready", 32'(HREADYOUT),   32'd1);
    check("w1_resp",  32'(HRESP),       32'd0);
    setup(32'h10, 1'b0, c_WORD, c_NONSEQ, 32'h0);
    check("r1_we_idle", 32'(mem_we_o),    32'd0);
    check("r1_raddr",   32'(mem_raddr_o), 32'd4);
    setup(32'h0, 1'b0, c_WORD, c_IDLE, 32'h0);
    check("r1_hrdata", HRDATA, 32'hDEADBEEF);
    setup(32'h0, 1'b0, c_WORD, c_IDLE, 32'h0);
    check("r1_hrdata_zero", HRDATA, 32'h0);

    // Byte write into an existing word
    wr_word(32'h20, 32'h11223344);
    setup(32'h21, 1'b1, c_BYTE, c_NONSEQ, 32'h0);
    setup(32'h0, 1'b0, c_WORD, c_IDLE, 32'h0000AA00);
    check("b_be",    32'(mem_be_o),    32'h2);
    check("b_waddr", 32'(mem_waddr_o), 32'd8);
    setup(32'h20, 1'b0, c_WORD, c_NONSEQ, 32'h0);
    setup(32'h0, 1'b0, c_WORD, c_IDLE, 32'h0);
    check("b_read", HRDATA, 32'h1122AA44);

    // Write followed immediately by read of the same word
    wr_word(32'h40, 32'hCAFEF00D);
    setup(32'h40, 1'b1, c_WORD, c_NONSEQ, 32'h0);
    setup(32'h40, 1'b0, c_WORD, c_SEQ, 32'h12345678);
    check("byp_we", 32'(mem_we_o), 32'd1);
    setup(32'h0, 1'b0, c_WORD, c_IDLE, 32'h0);
    check("byp_full", HRDATA, 32'h12345678);
    setup(32'h42, 1'b1, c_BYTE, c_NONSEQ, 32'h0);
    setup(32'h40, 1'b0, c_WORD, c_SEQ, 32'h00550000);
    check("byp_part_be", 32'(mem_be_o), 32'h4);
    setup(32'h0, 1'b0, c_WORD, c_IDLE, 32'h0);
    check("byp_merge", HRDATA, 32'h12555678);
    setup(32'h44, 1'b1, c_WORD, c_NONSEQ, 32'h0);
    setup(32'h40, 1'b0, c_WORD, c_SEQ, 32'hFFFFFFFF);
    setup(32'h0, 1'b0, c_WORD, c_IDLE, 32'h0);
    check("nobyp_other_word", HRDATA, 32'h12555678);

    // Misaligned halfword: two-cycle error, no RAM write
    setup(32'h03, 1'b1, c_HALF, c_NONSEQ, 32'h0);
    @(negedge clk_i);
    HTRANS = c_IDLE;
    HREADY = 1'b0;
    #1;
    check("e1_ready", 32'(HREADYOUT), 32'd0);
    check("e1_resp",  32'(HRESP),     32'd1);
    check("e1_we",    32'(mem_we_o),  32'd0);
    @(negedge clk_i);
    HREADY = 1'b1;
    #1;
    check("e2_ready", 32'(HREADYOUT), 32'd1);
    check("e2_resp",  32'(HRESP),     32'd1);
    check("e2_we",    32'(mem_we_o),  32'd0);
    setup(32'h0, 1'b0, c_WORD, c_IDLE, 32'h0);
    check("e_done_resp",  32'(HRESP),     32'd0);
    check("e_done_ready", 32'(HREADYOUT), 32'd1);

    // Oversized transfer is also an error
    setup(32'h0, 1'b0, c_DWORD, c_NONSEQ, 32'h0);
    @(negedge clk_i);
    HTRANS = c_IDLE;
    HREADY = 1'b0;
    #1;
    check("esz_resp",  32'(HRESP),     32'd1);
    check("esz_ready", 32'(HREADYOUT), 32'd0);
    @(negedge clk_i);
    HREADY = 1'b1;
    setup(32'h0, 1'b0, c_WORD, c_IDLE, 32'h0);

    // Reset during a write data phase
    wr_word(32'h50, 32'h0BADC0DE);
    setup(32'h50, 1'b1, c_WORD, c_NONSEQ, 32'h0);
    setup(32'h0, 1'b0, c_WORD, c_IDLE, 32'h99999999);
    check("rw_we_before", 32'(mem_we_o), 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("rw_we_rst",    32'(mem_we_o),  32'd0);
    check("rw_be_rst",    32'(mem_be_o),  32'd0);
    check("rw_ready_rst", 32'(HREADYOUT), 32'd1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    setup(32'h0, 1'b0, c_WORD, c_IDLE, 32'h99999999);
    check("rw_we_after", 32'(mem_we_o), 32'd0);
    setup(32'h50, 1'b0, c_WORD, c_NONSEQ, 32'h0);
    setup(32'h0, 1'b0, c_WORD, c_IDLE, 32'h0);
    check("rw_no_write", HRDATA, 32'h0BADC0DE);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/peripheral_spram_ahb3_bridge.md
PERIPHERAL_SPRAM_AHB3_BRIDGE -- requirements
Module: peripheral_spram_ahb3_bridge

Interface
REQ-001 SHALL have parameter HADDR_SIZE, default 32, AHB address width.
REQ-002 SHALL have parameter HDATA_SIZE, default 32, AHB data width (multiple of 8).
REQ-003 SHALL have parameter MEM_ABITS, default 10, RAM word-address width.
REQ-004 SHALL have ports in this order:
- rst_ni  in  1  asynchronous active-low reset
- clk_i  in  1  single clock, all logic on rising edge
- HSEL  in  1  slave select
- HADDR  in  HADDR_SIZE  address-phase address
- HWDATA  in  HDATA_SIZE  data-phase write data
- HRDATA  out  HDATA_SIZE  data-phase read data
- HWRITE  in  1  1 = write
- HSIZE  in  3  transfer size code
- HBURST  in  3  ignored
- HPROT  in  4  ignored
- HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ
- HMASTLOCK  in  1  ignored
- HREADY  in  1  bus ready (address phase accepted when high)
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0 = OKAY, 1 = ERROR
- mem_waddr_o  out  MEM_ABITS  RAM write word address
- mem_din_o  out  HDATA_SIZE  RAM write data
- mem_we_o  out  1  RAM write strobe
- mem_be_o  out  HDATA_SIZE/8  RAM byte enables
- mem_raddr_o  out  MEM_ABITS  RAM read word address
- mem_dout_i  in  HDATA_SIZE  RAM read data, registered, 1-cycle latency, no internal bypass

Function
REQ-005 SHALL accept a transfer when HSEL & HREADY & HTRANS in {NONSEQ, SEQ}; IDLE/BUSY SHALL give zero-wait OKAY with no RAM access.
REQ-006 SHALL form word address = HADDR[MEM_ABITS+log2(HDATA_SIZE/8)-1 : log2(HDATA_SIZE/8)]; upper address bits ignored (wrap).
REQ-007 SHALL form byte enables = (2**(2**HSIZE))-1 shifted left by HADDR low byte-offset bits.
REQ-008 SHALL flag error when 2**HSIZE > HDATA_SIZE/8 or HADDR not aligned to 2**HSIZE.
REQ-009 Error response SHALL be two cycles: ERR1 (HREADYOUT=0, HRESP=1), ERR2 (HREADYOUT=1, HRESP=1), then OKAY; erroneous transfers SHALL NOT write RAM.
REQ-010 State machine: OKAY -> ERR1 on accepted erroneous transfer; ERR1 -> ERR2 unconditionally; ERR2 -> OKAY, or ERR1 if HREADY was low... no: ERR2 -> OKAY always (no new transfer accepted during ERR1 since HREADY=0).
REQ-011 Valid transfers SHALL be zero-wait: HREADYOUT=1, HRESP=0.
REQ-012 Write: address/be captured in address phase; in data phase mem_we_o=1, mem_waddr_o=captured address, mem_din_o=HWDATA, mem_be_o=captured be.
REQ-013 Read: mem_raddr_o SHALL be combinational from HADDR in address phase; HRDATA in data phase = mem_dout_i.
REQ-014 Hazard: when a read address phase coincides with a write data phase to the same word, the bridge SHALL register HWDATA and be, and in the read data phase drive written byte lanes from the registered data, others from mem_dout_i.
REQ-015 HRDATA SHALL be 0 outside a read data phase.
REQ-016 Back-to-back transfers (NONSEQ then SEQ, mixed read/write) SHALL sustain one transfer per cycle.

Reset
REQ-017 On rst_ni low: state=OKAY, HREADYOUT=1, HRESP=0, HRDATA=0, mem_we_o=0, mem_be_o=0, pending write/read and bypass flags cleared, asynchronously.
REQ-018 A transfer whose address phase preceded reset SHALL NOT produce a RAM write after reset release.

Structure
REQ-019 HTRANS codes, HSIZE codes, HRESP codes SHALL live in a shared AHB3 package.
REQ-020 No sub-module; RAM is instantiated by the parent and connected via mem_* ports.

Verification
REQ-021 Word write 0xDEADBEEF to 0x10, read 0x10 -> mem_we_o=1 be=4'hF waddr=4; HRDATA=0xDEADBEEF.
REQ-022 Byte write 0xAA to 0x21 -> be=4'h2; subsequent word read returns prior word with byte1=0xAA.
REQ-023 Write 0x12345678 to 0x40 followed immediately by read 0x40 -> HRDATA=0x12345678 via bypass.
REQ-024 Halfword access at 0x03 -> ERR1 then ERR2 (HRESP=1 both, HREADYOUT 0 then 1), mem_we_o stays 0.
REQ-025 Assert rst_ni low during write data phase -> mem_we_o=0, HREADYOUT=1, no write after release.
